// File: rtl/cache_miss_arbiter.sv
// Refill sequencer for an I-cache and a D-cache sharing one pipelined main memory.
// Issues one word read per cycle for a block and steers in-order returns into the owning cache.
module cache_miss_arbiter #(
  parameter int unsigned BLOCK_WORDS = 8,
  parameter bit          PRIO_D      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_miss,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss,
  input  logic [15:0] d_miss_addr,
  input  logic        mem_data_valid,
  output logic        mem_enable,
  output logic [15:0] mem_addr,
  output logic        fill_i,
  output logic        fill_d,
  output logic [15:0] fill_word_addr,
  output logic        write_tag_i,
  output logic        write_tag_d,
  output logic        owner,
  output logic        stall
);

  localparam int unsigned AW   = 16;
  localparam int unsigned CW   = $clog2(BLOCK_WORDS) + 1;
  localparam int unsigned OFFW = $clog2(BLOCK_WORDS * 2);

  localparam logic [AW-1:0] ALIGN_MASK = ~AW'((32'd1 << OFFW) - 32'd1);
  localparam logic [CW-1:0] CNT_FULL   = CW'(BLOCK_WORDS);
  localparam logic [CW-1:0] CNT_LAST   = CW'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] issue_cnt_q, issue_cnt_d;
  logic [CW-1:0] recv_cnt_q, recv_cnt_d;
  logic [AW-1:0] base_q, base_d;
  logic          owner_q, owner_d;

  logic          any_miss_c;
  logic          grant_d_c;
  logic [CW-1:0] issue_idx_c;
  logic          mem_enable_c;
  logic [AW-1:0] mem_addr_c;
  logic          fill_i_c;
  logic          fill_d_c;
  logic [AW-1:0] fill_word_addr_c;
  logic          write_tag_i_c;
  logic          write_tag_d_c;

  // Grant selection: the priority cache wins only when both are missing.
  always_comb begin
    any_miss_c = i_miss | d_miss;
    grant_d_c  = d_miss & (PRIO_D | ~i_miss);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      base_q      <= '0;
      owner_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      base_q      <= base_d;
      owner_q     <= owner_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    issue_cnt_d      = issue_cnt_q;
    recv_cnt_d       = recv_cnt_q;
    base_d           = base_q;
    owner_d          = owner_q;
    mem_enable_c     = 1'b0;
    fill_i_c         = 1'b0;
    fill_d_c         = 1'b0;
    fill_word_addr_c = '0;
    write_tag_i_c    = 1'b0;
    write_tag_d_c    = 1'b0;

    // Once all reads are issued the address parks on the last word of the block.
    issue_idx_c = (issue_cnt_q < CNT_FULL) ? issue_cnt_q : CNT_LAST;
    mem_addr_c  = base_q + (AW'(issue_idx_c) << 1);

    unique case (state_q)
      S_IDLE: begin
        if (any_miss_c) begin
          owner_d     = grant_d_c;
          base_d      = (grant_d_c ? d_miss_addr : i_miss_addr) & ALIGN_MASK;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          state_d     = S_FILL;
        end
      end
      S_FILL: begin
        if (issue_cnt_q < CNT_FULL) begin
          mem_enable_c = 1'b1;
          issue_cnt_d  = issue_cnt_q + CW'(1);
        end
        // Returns are in order, so the receive count alone locates each word.
        if (mem_data_valid) begin
          fill_i_c         = ~owner_q;
          fill_d_c         = owner_q;
          fill_word_addr_c = base_q + (AW'(recv_cnt_q) << 1);
          recv_cnt_d       = recv_cnt_q + CW'(1);
          if (recv_cnt_q == CNT_LAST) begin
            write_tag_i_c = ~owner_q;
            write_tag_d_c = owner_q;
            state_d       = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes follow mem_data_valid in the same cycle, so they are decoded, not flopped.
  assign mem_enable     = mem_enable_c;
  assign mem_addr       = mem_addr_c;
  assign fill_i         = fill_i_c;
  assign fill_d         = fill_d_c;
  assign fill_word_addr = fill_word_addr_c;
  assign write_tag_i    = write_tag_i_c;
  assign write_tag_d    = write_tag_d_c;
  assign owner          = owner_q;
  assign stall          = rst & ((state_q != S_IDLE) | i_miss | d_miss);

endmodule

// File: doc/cache_miss_arbiter.md
Name: cache_miss_arbiter

Overview:
- Sequences block refills for the I-cache and the D-cache, which share one pipelined multi-cycle main memory.
- Accepts miss requests from both caches. D-cache has priority by default.
- Issues one 16-bit word read per cycle for the 8-word (16-byte) block.
- Steers the returning words into the owning cache's data array, writes that cache's tag array on the last word, and holds the pipeline stall until the cache re-lookup can hit.

Parameters:
- BLOCK_WORDS, 8: words per cache block. The block is BLOCK_WORDS*2 bytes; the base address is aligned to that size.
- PRIO_D, 1: 1 gives D-cache priority on simultaneous misses; 0 gives I-cache priority.

Ports:
- clk  in  1  system clock; everything is rising-edge.
- rst  in  1  asynchronous, active-low reset.
- i_miss  in  1  I-cache miss, level, held until serviced.
- i_miss_addr  in  16  I-cache miss byte address.
- d_miss  in  1  D-cache miss, level, held until serviced.
- d_miss_addr  in  16  D-cache miss byte address.
- mem_data_valid  in  1  memory read data valid this cycle; in-order return.
- mem_enable  out  1  memory read request this cycle.
- mem_addr  out  16  memory read byte address.
- fill_i  out  1  write_data_array strobe to the I-cache.
- fill_d  out  1  write_data_array strobe to the D-cache.
- fill_word_addr  out  16  byte address of the word being written into the cache (drives word_decoder).
- write_tag_i  out  1  write_tag_array strobe to the I-cache.
- write_tag_d  out  1  write_tag_array strobe to the D-cache.
- owner  out  1  current refill owner: 0 = I, 1 = D.
- stall  out  1  pipeline stall.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE. issue_cnt, recv_cnt, base and owner are cleared.
  - All outputs are 0 (mem_addr = 0, fill_word_addr = 0).
  - Reset mid-refill abandons the refill. Any memory data already in flight is ignored.
- States: IDLE, FILL, DONE.
- IDLE:
  - If either miss is high, grant per PRIO_D.
  - Latch base = miss_addr with its low log2(BLOCK_WORDS*2) bits cleared. Latch owner.
  - Clear both counters and go to FILL on the next edge.
  - mem_data_valid is ignored in IDLE.
- FILL, issue side:
  - While issue_cnt < BLOCK_WORDS: mem_enable=1, mem_addr = base + 2*issue_cnt, and issue_cnt increments.
  - After that, mem_enable=0 and mem_addr holds its last value.
- FILL, receive side:
  - When mem_data_valid=1: the owner's fill strobe is 1, fill_word_addr = base + 2*recv_cnt, and recv_cnt increments.
  - The non-owner strobes stay 0.
  - If mem_data_valid=1 while recv_cnt = BLOCK_WORDS-1, the owner's write_tag strobe is also 1 that same cycle, and the next state is DONE.
- DONE:
  - Lasts exactly one cycle. All strobes and mem_enable are 0.
  - The cache re-looks up and hits.
  - Next state is IDLE.
- stall = (state != IDLE) | i_miss | d_miss, combinational.
  - Stall therefore rises in the cycle the miss appears and falls the cycle after DONE, unless another miss is pending.
- Miss deasserted mid-refill: the refill still completes in full. The tag is still written.
- Both misses pending: the winner is fully served. The loser is granted in the IDLE cycle after DONE, with no starvation since it holds its level.
- The same cache missing again immediately after its DONE is a new grant.
- mem_data_valid arriving while issue_cnt=0 cannot occur; the arbiter does not check for it.
- Surplus mem_data_valid after the last word is never seen, because the state has left FILL.
- Counters are log2(BLOCK_WORDS)+1 bits wide. base+2*k does not wrap, because base is block-aligned.

Test Plan:
- D-miss: d_miss=1 with d_miss_addr=0x1234 at T0, bench memory latency 4.
  - FILL at T1; mem_addr = 0x1230, 0x1232, … 0x123E on T1..T8.
  - fill_d at T5..T12 with fill_word_addr 0x1230..0x123E.
  - write_tag_d=1 at T12 only; DONE at T13.
  - stall=1 from T0..T13, then 0 once d_miss drops.
- Simultaneous misses: i_miss (0x0048) and d_miss (0x2000) at T0, PRIO_D=1.
  - D refill first with owner=1 and no fill_i pulses.
  - I refill is granted the cycle after D's DONE, with base 0x0040 and owner=0.
  - stall stays 1 continuously throughout.
- PRIO_D=0, same stimulus: the I refill is served first.
- Miss withdrawn: d_miss drops at T3 → all 8 fill_d pulses and write_tag_d still occur; stall=0 after DONE.
- Reset mid-fill: rst low at T7 → all outputs 0 immediately, without a clock. Late mem_data_valid pulses after rst rises produce no fill strobes. A fresh miss is then served from word 0.
- Gapped returns: mem_data_valid with bubbles (valid on alternate cycles) → exactly 8 fill strobes, addresses strictly sequential, write_tag on the 8th valid.
